fpdiv_iter: RTL and testbench
=============================

FPDIV_ITER -- requirements
Module: fpdiv_iter

Interface
REQ-001 SHALL have clk, input, 1, sole clock; all state updates on the rising edge.
REQ-002 SHALL have rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have A, input, 16, IEEE half-precision dividend.
REQ-004 SHALL have B, input, 16, IEEE half-precision divisor.
REQ-005 SHALL have in_valid, input, 1, operands present.
REQ-006 SHALL have in_ready, output, 1, block can accept operands.
REQ-007 SHALL have Quotient, output, 16, half-precision result.
REQ-008 SHALL have out_valid, output, 1, result present.
REQ-009 SHALL have out_ready, input, 1, consumer accepts result.
REQ-010 SHALL have overflow, underflow and div_by_zero, each output, 1, status flags qualified by out_valid.

Function
REQ-011 SHALL implement the FSM states IDLE, DIV, NORM and DONE.
REQ-012 SHALL drive in_ready=1 only in IDLE; in_valid&in_ready latches A and B, enters DIV, and clears a 4-bit iteration counter.
REQ-013 SHALL decode each operand as sign, exp[14:10] and frac[9:0]; exp=0 is flush-to-zero (operand is zero); exp=31 is an ordinary value (no Inf/NaN decode).
REQ-014 SHALL form significands mA={1,fracA} and mB={1,fracB}, 11 bits each, for nonzero operands.
REQ-015 SHALL use restoring division in DIV: remainder R (12 bit) initialised to mA; per cycle for bit i=11..0: if R>=mB then q[i]=1 and R=R-mB, else q[i]=0; then R=R<<1.
REQ-016 SHALL spend exactly 12 cycles in DIV, then move to NORM; the result is q=floor(mA*2^11/mB), 12 bit, q[11]|q[10] always 1.
REQ-017 SHALL compute a signed 7-bit exponent in NORM: e=expA-expB+15-(q[11]?0:1).
REQ-018 SHALL take the mantissa from q[10:1] when q[11]=1, else from q[9:0]; truncation only, no rounding.
REQ-019 SHALL set the sign to signA^signB in all cases.
REQ-020 SHALL produce {sign,11111,0} with overflow=1 when e>=31.
REQ-021 SHALL produce {sign,00000,0} with underflow=1 when e<=0.
REQ-022 SHALL produce {sign,00000,0} with all flags 0 when A is zero and B is nonzero.
REQ-023 SHALL produce {sign,11111,0} with div_by_zero=1, overflow=0 when B is zero and A is nonzero.
REQ-024 SHALL produce 16'h7E00 with div_by_zero=1 when both A and B are zero.
REQ-025 SHALL still traverse DIV and NORM for the special cases of REQ-022 to REQ-024; latency is fixed for every operand.
REQ-026 SHALL register the result and flags at the NORM->DONE transition; out_valid=1 only in DONE.
REQ-027 SHALL raise out_valid 14 cycles after the accept edge.
REQ-028 SHALL hold Quotient and all flags stable in DONE while out_ready=0.
REQ-029 SHALL return to IDLE on out_valid&out_ready, with in_ready=1 on the next cycle; there is no same-cycle accept.
REQ-030 SHALL ignore in_valid outside IDLE; operands are not re-sampled.

Reset
REQ-031 SHALL force, while rst=1 at a clock edge: state=IDLE, in_ready=1, out_valid=0, Quotient=16'h0000, all flags 0, and counter, R and q cleared.
REQ-032 SHALL abort any division in progress on reset asserted mid-operation; no out_valid follows for that operation.

Verification
REQ-033 SHALL cover 0x4000/0x3C00 (2/1), out_ready=1 -> Quotient=0x4000, all flags 0, out_valid at cycle 14 after accept.
REQ-034 SHALL cover 0x3C00/0x4200 (1/3) -> Quotient=0x3555 (q=1365, e=13), all flags 0.
REQ-035 SHALL cover 0x7800/0x0400 -> Quotient=0x7C00, overflow=1.
REQ-036 SHALL cover 0x0400/0x7800 -> Quotient=0x0000, underflow=1.
REQ-037 SHALL cover 0xBC00/0x0000 -> Quotient=0xFC00, div_by_zero=1; and 0x0000/0x0000 -> 0x7E00, div_by_zero=1.
REQ-038 SHALL cover 0xC000/0x3C00 with out_ready=0 for 5 cycles -> 0xC000 held stable with out_valid=1 and in_ready=0; release gives in_ready=1 one cycle after the handshake; rst pulsed at DIV cycle 6 -> IDLE with no out_valid.

Source files
------------

// File: rtl/fpdiv_iter_if.sv
// Operand/result handshake bundle for the iterative half-precision divider.
// The slave side is the divider, the master side is the requester.
interface fpdiv_iter_if;
  logic [15:0] A;
  logic [15:0] B;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] Quotient;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic        underflow;
  logic        div_by_zero;

  modport slave (
    input  A, B, in_valid, out_ready,
    output in_ready, Quotient, out_valid,
    output overflow, underflow, div_by_zero
  );

  modport master (
    output A, B, in_valid, out_ready,
    input  in_ready, Quotient, out_valid,
    input  overflow, underflow, div_by_zero
  );
endinterface

// File: rtl/fpdiv_iter.sv
// Half-precision divider: 12-step restoring division, then normalise.
// Fixed latency for every operand pair, including zero operands.
module fpdiv_iter (
  input  logic clk,
  input  logic rst,
  fpdiv_iter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, DIV, NORM, DONE
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [11:0] r_q, r_d;
  logic [11:0] q_q, q_d;
  logic [15:0] quo_q, quo_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic        dbz_q, dbz_d;

  logic [11:0]       mb;
  logic [11:0]       diff;
  logic              az;
  logic              bz;
  logic              sgn;
  logic signed [6:0] e;
  logic [9:0]        mant;

  assign mb   = {2'b01, b_q[9:0]};
  assign diff = r_q - mb;
  assign az   = (a_q[14:10] == 5'd0);
  assign bz   = (b_q[14:10] == 5'd0);
  assign sgn  = a_q[15] ^ b_q[15];
  assign e    = $signed({2'b00, a_q[14:10]})
              - $signed({2'b00, b_q[14:10]})
              + 7'sd15
              - (q_q[11] ? 7'sd0 : 7'sd1);
  assign mant = q_q[11] ? q_q[10:1] : q_q[9:0];

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.Quotient    = quo_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;
  assign bus.div_by_zero = dbz_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      quo_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      quo_q   <= quo_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    quo_d   = quo_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.A;
          b_d     = bus.B;
          cnt_d   = 4'd0;
          r_d     = {2'b01, bus.A[9:0]};
          q_d     = '0;
          state_d = DIV;
        end
      end
      DIV: begin
        if (r_q >= mb) begin
          q_d = {q_q[10:0], 1'b1};
          r_d = diff << 1;
        end else begin
          q_d = {q_q[10:0], 1'b0};
          r_d = r_q << 1;
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd11) state_d = NORM;
      end
      NORM: begin
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        dbz_d   = 1'b0;
        state_d = DONE;
        // zero-operand cases override the arithmetic result
        unique case (1'b1)
          az && bz: begin
            quo_d = 16'h7E00;
            dbz_d = 1'b1;
          end
          !az && bz: begin
            quo_d = {sgn, 5'h1F, 10'h000};
            dbz_d = 1'b1;
          end
          az && !bz: begin
            quo_d = {sgn, 15'h0000};
          end
          !az && !bz && (e >= 7'sd31): begin
            quo_d = {sgn, 5'h1F, 10'h000};
            ovf_d = 1'b1;
          end
          !az && !bz && (e <= 7'sd0): begin
            quo_d = {sgn, 15'h0000};
            unf_d = 1'b1;
          end
          !az && !bz && (e > 7'sd0) && (e < 7'sd31): begin
            quo_d = {sgn, e[4:0], mant};
          end
        endcase
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_fpdiv_iter.sv
// Bench for fpdiv_iter: directed corners plus random operands
// against an arithmetic reference of the half-precision divide.
module tb_fpdiv_iter;
  logic clk;
  logic rst;
  int checks;
  int errors;

  fpdiv_iter_if bus ();

  fpdiv_iter dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // returns {overflow, underflow, div_by_zero, quotient}
  function automatic logic [18:0] model(input logic [15:0] a,
                                         input logic [15:0] b);
    int ea, eb, ma, mb, q, e, mant;
    logic s;
    logic [15:0] r;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    s  = a[15] ^ b[15];
    if (ea == 0 && eb == 0) return {3'b001, 16'h7E00};
    if (eb == 0) return {3'b001, s, 5'h1F, 10'h000};
    if (ea == 0) return {3'b000, s, 15'h0000};
    ma = 1024 + int'(a[9:0]);
    mb = 1024 + int'(b[9:0]);
    q  = (ma * 2048) / mb;
    if (q >= 2048) begin
      e    = ea - eb + 15;
      mant = (q / 2) % 1024;
    end else begin
      e    = ea - eb + 14;
      mant = q % 1024;
    end
    if (e >= 31) return {3'b100, s, 5'h1F, 10'h000};
    if (e <= 0) return {3'b010, s, 15'h0000};
    r = {s, e[4:0], mant[9:0]};
    return {3'b000, r};
  endfunction

  // Issue one operation; return the result and its latency in cycles,
  // counting the cycle that starts at the accept edge as cycle 1.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic ordy,
                       output logic [18:0] res, output int lat,
                       output bit to);
    bus.A         = a;
    bus.B         = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = ordy;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    to  = 1'b0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.out_valid) to = 1'b1;
    res = {bus.overflow, bus.underflow, bus.div_by_zero, bus.Quotient};
    if (ordy && !to) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [19:0] got;
    rst           = 1'b1;
    bus.A         = 16'h1234;
    bus.B         = 16'h4321;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    got = {bus.in_ready, bus.out_valid, bus.overflow,
           bus.underflow, bus.div_by_zero, bus.Quotient[14:0]};
    checks++;
    if (got !== {1'b1, 4'b0000, 15'h0} || bus.Quotient[15] !== 1'b0) begin
      errors++;
      $display("FAIL reset: got rdy/vld/flags/q=%h required %h",
               {bus.in_ready, bus.out_valid, bus.overflow,
                bus.underflow, bus.div_by_zero, bus.Quotient},
               {5'b10000, 16'h0000});
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [15:0] va [7];
    logic [15:0] vb [7];
    logic [18:0] exp_v [7];
    logic [18:0] res;
    int lat;
    bit to;
    va[0] = 16'h4000; vb[0] = 16'h3C00; exp_v[0] = {3'b000, 16'h4000};
    va[1] = 16'h3C00; vb[1] = 16'h4200; exp_v[1] = {3'b000, 16'h3555};
    va[2] = 16'h7800; vb[2] = 16'h0400; exp_v[2] = {3'b100, 16'h7C00};
    va[3] = 16'h0400; vb[3] = 16'h7800; exp_v[3] = {3'b010, 16'h0000};
    va[4] = 16'hBC00; vb[4] = 16'h0000; exp_v[4] = {3'b001, 16'hFC00};
    va[5] = 16'h0000; vb[5] = 16'h0000; exp_v[5] = {3'b001, 16'h7E00};
    va[6] = 16'h8000; vb[6] = 16'h3C00; exp_v[6] = {3'b000, 16'h8000};
    for (int i = 0; i < 7; i++) begin
      do_op(va[i], vb[i], 1'b1, res, lat, to);
      checks++;
      if (to || res !== exp_v[i]) begin
        errors++;
        $display("FAIL directed %h/%h: got %h required %h timeout=%0d",
                 va[i], vb[i], res, exp_v[i], to);
      end
      checks++;
      if (lat != 14) begin
        errors++;
        $display("FAIL latency %h/%h: got %0d required 14",
                 va[i], vb[i], lat);
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL in_ready after handshake: got %b required 1",
                 bus.in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [18:0] res;
    int lat;
    bit to;
    do_op(16'hC000, 16'h3C00, 1'b0, res, lat, to);
    checks++;
    if (to || res !== {3'b000, 16'hC000}) begin
      errors++;
      $display("FAIL hold result: got %h required %h", res,
               {3'b000, 16'hC000});
    end
    // new operands offered while the result is held must be ignored
    bus.A        = 16'h7800;
    bus.B        = 16'h0400;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.overflow, bus.underflow,
           bus.div_by_zero, bus.Quotient} !== {5'b10000, 16'hC000}) begin
        errors++;
        $display("FAIL hold cycle %0d: got vld/rdy/flags/q=%b%b%b%b%b %h required 10000 c000",
                 c, bus.out_valid, bus.in_ready, bus.overflow,
                 bus.underflow, bus.div_by_zero, bus.Quotient);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL release: got rdy=%b vld=%b required rdy=1 vld=0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    bus.A         = 16'h4000;
    bus.B         = 16'h3C00;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.Quotient !== 16'h0000) begin
      errors++;
      $display("FAIL abort reset: got rdy=%b q=%h required rdy=1 q=0000",
               bus.in_ready, bus.Quotient);
    end
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort out_valid: got %0d cycles required 0", seen);
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    logic [18:0] res, exp_r;
    int lat;
    bit to;
    for (int i = 0; i < 150; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 9) == 0) a[14:10] = 5'd0;
      if ($urandom_range(0, 9) == 0) b[14:10] = 5'd0;
      if ($urandom_range(0, 2) == 0) b[14:10] = a[14:10];
      exp_r = model(a, b);
      do_op(a, b, 1'b1, res, lat, to);
      checks++;
      if (to || res !== exp_r || lat != 14) begin
        errors++;
        $display("FAIL random %h/%h: got %h lat %0d required %h lat 14",
                 a, b, res, lat, exp_r);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [18:0] r1, r2;
    int l1, l2;
    bit t1, t2;
    do_op(16'h4400, 16'h4000, 1'b1, r1, l1, t1);
    do_op(16'h3800, 16'hC400, 1'b1, r2, l2, t2);
    checks++;
    if (t1 || r1 !== model(16'h4400, 16'h4000)) begin
      errors++;
      $display("FAIL b2b first: got %h required %h", r1,
               model(16'h4400, 16'h4000));
    end
    checks++;
    if (t2 || r2 !== model(16'h3800, 16'hC400)) begin
      errors++;
      $display("FAIL b2b second: got %h required %h", r2,
               model(16'h3800, 16'hC400));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
